// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - decoder-to-muldiv handshake and HI/LO access bundle
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             md_start;
    logic [1:0]       md_op;
    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hilo_wdata;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output md_start, md_op, md_a, md_b, hi_we, lo_we, hilo_wdata,
        input  md_busy, md_done, hi, lo
    );

    modport slave (
        input  md_start, md_op, md_a, md_b, hi_we, lo_we, hilo_wdata,
        output md_busy, md_done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit owning HI/LO
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic               is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0]   a_orig, b_mag, acc_hi, acc_lo;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               done_r;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   sub_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign signed_op = ~bus.md_op[0];
    assign a_neg     = signed_op & bus.md_a[WIDTH-1];
    assign b_neg     = signed_op & bus.md_b[WIDTH-1];
    assign a_mag_in  = a_neg ? -bus.md_a : bus.md_a;
    assign b_mag_in  = b_neg ? -bus.md_b : bus.md_b;

    // Multiply: acc_hi:acc_lo is the 64-bit accumulator, multiplier shifts out of acc_lo.
    assign add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, b_mag};
    assign sub_diff  = rem_shift[WIDTH-1:0] - b_mag;

    assign prod      = {acc_hi, acc_lo};
    assign prod_fix  = neg_q ? -prod : prod;
    assign q_fix     = neg_q ? -acc_lo : acc_lo;
    assign r_fix     = neg_r ? -acc_hi : acc_hi;

    assign bus.md_busy = (state != IDLE);
    assign bus.md_done = done_r;
    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.md_start) state_nxt = RUN;
            RUN:     if (count == CNT_W'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            a_orig   <= '0;
            b_mag    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_r <= bus.hilo_wdata;
                    if (bus.lo_we) lo_r <= bus.hilo_wdata;
                    if (bus.md_start) begin
                        is_div   <= bus.md_op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= bus.md_op[1] & (bus.md_b == '0);
                        a_orig   <= bus.md_a;
                        b_mag    <= b_mag_in;
                        acc_hi   <= '0;
                        acc_lo   <= a_mag_in;
                        count    <= '0;
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (is_div) begin
                        acc_hi <= rem_ge ? sub_diff : rem_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
                    end else begin
                        acc_hi <= add_sum[WIDTH:1];
                        acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    count  <= '0;
                    done_r <= 1'b1;
                    if (!is_div) begin
                        {hi_r, lo_r} <= prod_fix;
                    end else if (div_zero) begin
                        hi_r <= a_orig;
                        lo_r <= '1;
                    end else begin
                        hi_r <= r_fix;
                        lo_r <= q_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference result {hi, lo} straight from arithmetic definitions.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint q, r;
        case (op)
            2'b00: return sa * sb;
            2'b01: return {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Cycle-level model: 33 busy cycles after an accepted start, then result + done.
    logic [31:0] m_hi, m_lo;
    logic        m_done;
    int          m_rem;
    logic [63:0] m_pend;
    logic        m_valid = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= 0; m_lo <= 0; m_done <= 0; m_rem <= 0; m_valid <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 1) begin
                m_rem <= m_rem - 1;
            end else if (m_rem == 1) begin
                m_rem  <= 0;
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
                m_done <= 1'b1;
            end else begin
                if (bus.hi_we) m_hi <= bus.hilo_wdata;
                if (bus.lo_we) m_lo <= bus.hilo_wdata;
                if (bus.md_start) begin
                    m_pend <= ref_result(bus.md_op, bus.md_a, bus.md_b);
                    m_rem  <= 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", {63'b0, bus.md_busy}, {63'b0, m_rem != 0});
            check("done", {63'b0, bus.md_done}, {63'b0, m_done});
            check("hi",   {32'b0, bus.hi}, {32'b0, m_hi});
            check("lo",   {32'b0, bus.lo}, {32'b0, m_lo});
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic hw, input logic lw, input logic [31:0] wd,
                          input logic lit, input logic [31:0] ehi, input logic [31:0] elo,
                          input string nm, input logic disturb);
        int cnt;
        @(negedge clk);
        bus.md_start = 1'b1; bus.md_op = op; bus.md_a = a; bus.md_b = b;
        bus.hi_we = hw; bus.lo_we = lw; bus.hilo_wdata = wd;
        @(negedge clk);
        bus.md_start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.md_a = $urandom; bus.md_b = $urandom;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.md_busy) break;
            cnt++;
            if (disturb && cnt == 3) begin
                bus.md_start = 1'b1; bus.md_op = 2'($urandom_range(0, 3));
                bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.hilo_wdata = 32'hDEAD_BEEF;
            end else begin
                bus.md_start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
            end
            @(negedge clk);
        end
        bus.md_start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check({nm, "_busy_cycles"}, 64'(cnt), 64'd33);
        check({nm, "_done"}, {63'b0, bus.md_done}, 64'd1);
        if (lit) begin
            check({nm, "_hi"}, {32'b0, bus.hi}, {32'b0, ehi});
            check({nm, "_lo"}, {32'b0, bus.lo}, {32'b0, elo});
        end
        @(negedge clk);
        check({nm, "_done_pulse"}, {63'b0, bus.md_done}, 64'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        bus.md_start = 0; bus.md_op = 0; bus.md_a = 0; bus.md_b = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.hilo_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'b0, bus.md_busy}, 64'd0);
        check("rst_done", {63'b0, bus.md_done}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;

        check("ref_multu", ref_result(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        check("ref_mult",  ref_result(2'b00, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        check("ref_div_ovf", ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        check("ref_div_neg", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", 0);
        run_op(2'b11, 32'd100, 32'd7, 0, 0, 0, 1, 32'd2, 32'd14, "divu", 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 1, 32'd0, 32'h8000_0000, "div_ovf", 0);
        run_op(2'b10, 32'd123, 32'd0, 0, 0, 0, 1, 32'd123, 32'hFFFF_FFFF, "div_zero", 0);
        run_op(2'b10, 32'hFFFF_FF85, 32'd0, 0, 0, 0, 1, 32'hFFFF_FF85, 32'hFFFF_FFFF, "div_zero_neg", 0);
        run_op(2'b11, 32'd100, 32'd7, 0, 0, 0, 1, 32'd2, 32'd14, "busy_ignore", 1);

        @(negedge clk);
        bus.hi_we = 1'b1; bus.hilo_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi_hi", {32'b0, bus.hi}, {32'b0, 32'hDEAD_BEEF});
        check("mthi_lo", {32'b0, bus.lo}, 64'd14);
        bus.lo_we = 1'b1; bus.hilo_wdata = 32'h1234_5678;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo_lo", {32'b0, bus.lo}, {32'b0, 32'h1234_5678});
        check("mtlo_hi", {32'b0, bus.hi}, {32'b0, 32'hDEAD_BEEF});

        run_op(2'b01, 32'd6, 32'd7, 1, 1, 32'h5555_AAAA, 1, 32'd0, 32'd42, "start_with_mt", 0);

        @(negedge clk);
        bus.md_start = 1'b1; bus.md_op = 2'b01; bus.md_a = 32'hFFFF_FFFF; bus.md_b = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.md_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {63'b0, bus.md_busy}, 64'd0);
        check("abort_done", {63'b0, bus.md_done}, 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(2'b01, 32'd3, 32'd5, 0, 0, 0, 1, 32'd0, 32'd15, "after_abort", 0);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: b = $urandom_range(1, 3);
                default: ;
            endcase
            run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                   0, 0, 0, "rand", 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                bus.hi_we = 1'($urandom_range(0, 1)); bus.lo_we = 1'($urandom_range(0, 1));
                bus.hilo_wdata = $urandom;
                @(negedge clk);
                bus.hi_we = 1'b0; bus.lo_we = 1'b0;
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
